// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// active-low segment codes ({g,f,e,d,c,b,a}), blank code and scan-phase helpers.
package seg_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}
    localparam seg_t SEG_HEX_0 = 7'h40;
    localparam seg_t SEG_HEX_1 = 7'h79;
    localparam seg_t SEG_HEX_2 = 7'h24;
    localparam seg_t SEG_HEX_3 = 7'h30;
    localparam seg_t SEG_HEX_4 = 7'h19;
    localparam seg_t SEG_HEX_5 = 7'h12;
    localparam seg_t SEG_HEX_6 = 7'h02;
    localparam seg_t SEG_HEX_7 = 7'h78;
    localparam seg_t SEG_HEX_8 = 7'h00;
    localparam seg_t SEG_HEX_9 = 7'h10;
    localparam seg_t SEG_HEX_A = 7'h08;
    localparam seg_t SEG_HEX_B = 7'h03;
    localparam seg_t SEG_HEX_C = 7'h46;
    localparam seg_t SEG_HEX_D = 7'h21;
    localparam seg_t SEG_HEX_E = 7'h06;
    localparam seg_t SEG_HEX_F = 7'h0E;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Phase 3 is the first phase of every digit slot and is always dark,
    // so ghosting from the previous digit never bleeds into the next one.
    localparam logic [1:0] PHASE_GUARD  = 2'd3;
    localparam logic [1:0] PHASE_TOP    = 2'd3;
    localparam logic [1:0] BRIGHT_RESET = 2'd1;

    // A phase is lit when it is not the guard phase and lies within the
    // 'bright' phases immediately following the guard (counting down).
    function automatic logic phase_lit(input logic [1:0] phase, input logic [1:0] bright);
        phase_lit = (phase != PHASE_GUARD) && (phase >= (PHASE_TOP - bright));
    endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);
    import seg_scan_driver_pkg::*;

    // Glyph lookup; unreachable default keeps the display dark.
    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0:    seg_n = SEG_HEX_0;
            4'h1:    seg_n = SEG_HEX_1;
            4'h2:    seg_n = SEG_HEX_2;
            4'h3:    seg_n = SEG_HEX_3;
            4'h4:    seg_n = SEG_HEX_4;
            4'h5:    seg_n = SEG_HEX_5;
            4'h6:    seg_n = SEG_HEX_6;
            4'h7:    seg_n = SEG_HEX_7;
            4'h8:    seg_n = SEG_HEX_8;
            4'h9:    seg_n = SEG_HEX_9;
            4'hA:    seg_n = SEG_HEX_A;
            4'hB:    seg_n = SEG_HEX_B;
            4'hC:    seg_n = SEG_HEX_C;
            4'hD:    seg_n = SEG_HEX_D;
            4'hE:    seg_n = SEG_HEX_E;
            4'hF:    seg_n = SEG_HEX_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver. A prescaler produces scan ticks; a
// down-counting scan counter walks 4 phases per digit, highest digit first.
// Displayed data and brightness are double-buffered and swap only at the
// frame wrap so a frame never shows a mix of old and new digits.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [1:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);
    import seg_scan_driver_pkg::*;

    localparam int SCAN_N  = 4 * NUM_DIGITS;
    localparam int SCAN_W  = $clog2(SCAN_N);
    localparam int DIG_W   = SCAN_W - 2;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DATA_W  = 4 * NUM_DIGITS;

    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_N - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ZERO = {SCAN_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};

    logic [PRESC_W-1:0]    presc_q,   presc_d;
    logic [SCAN_W-1:0]     scan_q,    scan_d;
    logic [DATA_W-1:0]     pend_q,    pend_d;
    logic                  flag_q,    flag_d;
    logic [DATA_W-1:0]     shadow_q,  shadow_d;
    logic [1:0]            bright_q,  bright_d;
    logic [NUM_DIGITS-1:0] an_q,      an_d;
    logic [6:0]            seg_q,     seg_d;
    logic                  fdone_q,   fdone_d;

    logic                  tick_s;
    logic                  wrap_s;
    logic [DIG_W-1:0]      digit_s;
    logic [1:0]            phase_s;
    logic [3:0]            nibble_s;
    logic [6:0]            glyph_s;
    logic                  lit_s;

    assign digit_s  = scan_q[SCAN_W-1:2];
    assign phase_s  = scan_q[1:0];
    assign nibble_s = shadow_q[{digit_s, 2'b00} +: 4];
    assign lit_s    = phase_lit(phase_s, bright_q);

    hex_to_7seg u_hex (
        .nibble (nibble_s),
        .seg_n  (glyph_s)
    );

    // Tick generation: prescaler only runs while scanning is enabled.
    always_comb begin
        tick_s = 1'b0;
        wrap_s = 1'b0;
        if (en && (presc_q == PRESC_ZERO)) begin
            tick_s = 1'b1;
            wrap_s = (scan_q == SCAN_ZERO);
        end else begin
            tick_s = 1'b0;
            wrap_s = 1'b0;
        end
    end

    // Next-state for prescaler, scan counter and the double-buffered data.
    always_comb begin
        presc_d  = presc_q;
        scan_d   = scan_q;
        pend_d   = pend_q;
        flag_d   = flag_q;
        shadow_d = shadow_q;
        bright_d = bright_q;

        if (!en) begin
            presc_d = presc_q;
        end else if (tick_s) begin
            presc_d = PRESC_MAX;
        end else begin
            presc_d = presc_q - PRESC_W'(1);
        end

        if (!tick_s) begin
            scan_d = scan_q;
        end else if (scan_q == SCAN_ZERO) begin
            scan_d = SCAN_MAX;
        end else begin
            scan_d = scan_q - SCAN_W'(1);
        end

        // Loads are accepted regardless of en; last one before the wrap wins.
        if (load) begin
            pend_d = data_in;
            flag_d = 1'b1;
        end else begin
            pend_d = pend_q;
            flag_d = flag_q;
        end

        // Frame boundary: publish pending data and latch brightness.
        // A load landing on the wrap tick goes straight to the shadow.
        if (wrap_s) begin
            bright_d = brightness;
            flag_d   = 1'b0;
            if (load) begin
                shadow_d = data_in;
            end else if (flag_q) begin
                shadow_d = pend_q;
            end else begin
                shadow_d = shadow_q;
            end
        end else begin
            bright_d = bright_q;
            shadow_d = shadow_q;
        end
    end

    // Output decode from the current scan position, registered next edge.
    always_comb begin
        an_d    = {NUM_DIGITS{1'b1}};
        seg_d   = SEG_BLANK;
        fdone_d = wrap_s;
        if (en && lit_s) begin
            an_d[digit_s] = 1'b0;
            seg_d         = glyph_s;
        end else begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = SEG_BLANK;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= PRESC_MAX;
            scan_q   <= SCAN_MAX;
            pend_q   <= {DATA_W{1'b0}};
            flag_q   <= 1'b0;
            shadow_q <= {DATA_W{1'b0}};
            bright_q <= BRIGHT_RESET;
            an_q     <= {NUM_DIGITS{1'b1}};
            seg_q    <= SEG_BLANK;
            fdone_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            scan_q   <= scan_d;
            pend_q   <= pend_d;
            flag_q   <= flag_d;
            shadow_q <= shadow_d;
            bright_q <= bright_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fdone_q  <= fdone_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fdone_q;

endmodule
